// File: rtl/block_commit_rob_if.sv
// block_commit_rob_if: dispatch, completion and commit handshakes of the commit ROB.
//   alloc_*  : dispatcher allocation request (alloc_ready from the ROB)
//   done_*   : per-core completion strobes, IDs and register write masks (flattened)
//   commit_* : in-order retirement to the commit consumer (commit_ready from the consumer)
//   master = dispatcher/cores/consumer side, slave = ROB side
interface block_commit_rob_if #(
  parameter int NUM_CORES = 3,
  parameter int ID_W = 8
);
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  logic alloc_valid;
  logic [ID_W-1:0] alloc_id;
  logic alloc_ready;
  logic [NUM_CORES-1:0] done_valid;
  logic [NUM_CORES*ID_W-1:0] done_id;
  logic [NUM_CORES*32-1:0] done_wmask;
  logic commit_valid;
  logic [ID_W-1:0] commit_id;
  logic [CW-1:0] commit_core;
  logic [31:0] commit_wmask;
  logic commit_ready;
  modport master (
    output alloc_valid, alloc_id, done_valid, done_id, done_wmask, commit_ready,
    input alloc_ready, commit_valid, commit_id, commit_core, commit_wmask
  );
  modport slave (
    input alloc_valid, alloc_id, done_valid, done_id, done_wmask, commit_ready,
    output alloc_ready, commit_valid, commit_id, commit_core, commit_wmask
  );
endinterface

// File: rtl/block_commit_rob.sv
// block_commit_rob: in-order commit buffer retiring out-of-order core completions in allocation order.
//   clk, rst (async active-low), flush (sync clear of all entries, err flags kept)
//   bus   : alloc / done / commit handshakes (slave side)
//   count : live entries; err_unknown_id / err_dup_done : sticky completion errors
module block_commit_rob #(
  parameter int NUM_CORES = 3,
  parameter int ROB_DEPTH = 8,
  parameter int ID_W = 8,
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1,
  localparam int PW = $clog2(ROB_DEPTH),
  localparam int CNTW = PW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  block_commit_rob_if.slave bus,
  output logic [CNTW-1:0] count,
  output logic err_unknown_id,
  output logic err_dup_done
);
  logic [PW:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_DEPTH-1:0] live_q, live_d, done_q, done_d;
  logic [ROB_DEPTH-1:0][ID_W-1:0] id_q, id_d;
  logic [ROB_DEPTH-1:0][CW-1:0] core_q, core_d;
  logic [ROB_DEPTH-1:0][31:0] wmask_q, wmask_d;
  logic cv_q, cv_d;
  logic [ID_W-1:0] cid_q, cid_d;
  logic [CW-1:0] ccore_q, ccore_d;
  logic [31:0] cwm_q, cwm_d;
  logic [CNTW-1:0] count_q, count_d;
  logic eu_q, eu_d, ed_q, ed_d;
  logic [PW-1:0] hp, tp;
  logic full, do_alloc, pop, dup, hit;
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    live_d = live_q;
    done_d = done_q;
    id_d = id_q;
    core_d = core_q;
    wmask_d = wmask_q;
    cv_d = cv_q;
    cid_d = cid_q;
    ccore_d = ccore_q;
    cwm_d = cwm_q;
    count_d = count_q;
    eu_d = eu_q;
    ed_d = ed_q;
    dup = 1'b0;
    hit = 1'b0;
    hp = head_q[PW-1:0];
    tp = tail_q[PW-1:0];
    full = (hp == tp) && (head_q[PW] != tail_q[PW]);
    do_alloc = bus.alloc_valid && !full;
    pop = live_q[hp] && done_q[hp] && (!cv_q || bus.commit_ready);
    // Matching uses registered live/done only, so an entry allocated this cycle never matches.
    for (int c = 0; c < NUM_CORES; c++) begin
      if (bus.done_valid[c]) begin
        dup = 1'b0;
        hit = 1'b0;
        for (int d = 0; d < c; d++)
          if (bus.done_valid[d] && bus.done_id[d*ID_W +: ID_W] == bus.done_id[c*ID_W +: ID_W]) dup = 1'b1;
        if (!dup)
          for (int i = 0; i < ROB_DEPTH; i++)
            if (live_q[i] && !done_q[i] && id_q[i] == bus.done_id[c*ID_W +: ID_W]) begin
              done_d[i] = 1'b1;
              core_d[i] = CW'(c);
              wmask_d[i] = bus.done_wmask[c*32 +: 32];
              hit = 1'b1;
            end
        ed_d = ed_d | dup;
        eu_d = eu_d | (!dup && !hit);
      end
    end
    if (do_alloc) begin
      live_d[tp] = 1'b1;
      done_d[tp] = 1'b0;
      id_d[tp] = bus.alloc_id;
      core_d[tp] = '0;
      wmask_d[tp] = '0;
      tail_d = tail_q + (PW+1)'(1);
    end
    if (pop) begin
      cv_d = 1'b1;
      cid_d = id_q[hp];
      ccore_d = core_q[hp];
      cwm_d = wmask_q[hp];
      live_d[hp] = 1'b0;
      done_d[hp] = 1'b0;
      head_d = head_q + (PW+1)'(1);
    end else if (cv_q && bus.commit_ready) begin
      cv_d = 1'b0;
    end
    count_d = count_q + CNTW'(do_alloc) - CNTW'(pop);
    // Flush discards everything in flight this cycle, including completions, but keeps the sticky errors.
    if (flush) begin
      live_d = '0;
      done_d = '0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
      cv_d = 1'b0;
      eu_d = eu_q;
      ed_d = ed_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      live_q <= '0;
      done_q <= '0;
      id_q <= '0;
      core_q <= '0;
      wmask_q <= '0;
      cv_q <= 1'b0;
      cid_q <= '0;
      ccore_q <= '0;
      cwm_q <= '0;
      count_q <= '0;
      eu_q <= 1'b0;
      ed_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      live_q <= live_d;
      done_q <= done_d;
      id_q <= id_d;
      core_q <= core_d;
      wmask_q <= wmask_d;
      cv_q <= cv_d;
      cid_q <= cid_d;
      ccore_q <= ccore_d;
      cwm_q <= cwm_d;
      count_q <= count_d;
      eu_q <= eu_d;
      ed_q <= ed_d;
    end
  end
  assign bus.alloc_ready = !full;
  assign bus.commit_valid = cv_q;
  assign bus.commit_id = cid_q;
  assign bus.commit_core = ccore_q;
  assign bus.commit_wmask = cwm_q;
  assign count = count_q;
  assign err_unknown_id = eu_q;
  assign err_dup_done = ed_q;
endmodule

// File: tb/tb_block_commit_rob.sv
// tb_block_commit_rob: directed and randomized checks of block_commit_rob against a queue-based model.
module tb_block_commit_rob;
  localparam int NC = 3;
  localparam int D = 8;
  localparam int IW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [3:0] count;
  logic eu, ed;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  block_commit_rob_if #(.NUM_CORES(NC), .ID_W(IW)) bus();
  block_commit_rob #(.NUM_CORES(NC), .ROB_DEPTH(D), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .count(count), .err_unknown_id(eu), .err_dup_done(ed)
  );
  typedef struct {logic [7:0] id; bit done; logic [1:0] core; logic [31:0] wm;} ent_t;
  ent_t q[$];
  bit m_cv, m_eu, m_ed;
  logic [7:0] m_cid;
  logic [1:0] m_ccore;
  logic [31:0] m_cwm;
  logic [7:0] gid[$];
  logic [1:0] gcore[$];
  logic [31:0] gwm[$];
  function automatic logic [31:0] wmf(logic [7:0] id, int c);
    return {8'hA5, 8'(c), 8'h3C, id};
  endfunction
  function automatic void model_reset();
    q.delete();
    m_cv = 0; m_eu = 0; m_ed = 0; m_cid = '0; m_ccore = '0; m_cwm = '0;
  endfunction
  // Program-order queue of live blocks; the front is the oldest.
  function automatic void model_step();
    bit pop, aok, dup, hit;
    logic [7:0] idc;
    if (flush) begin
      q.delete();
      m_cv = 0;
      return;
    end
    pop = q.size() > 0 && q[0].done && (!m_cv || bus.commit_ready);
    aok = bus.alloc_valid && q.size() < D;
    for (int c = 0; c < NC; c++) begin
      if (bus.done_valid[c]) begin
        idc = bus.done_id[c*IW +: IW];
        dup = 0;
        hit = 0;
        for (int d = 0; d < c; d++) if (bus.done_valid[d] && bus.done_id[d*IW +: IW] == idc) dup = 1;
        if (dup) m_ed = 1;
        else begin
          foreach (q[k]) if (!q[k].done && q[k].id == idc) begin
            q[k].done = 1; q[k].core = 2'(c); q[k].wm = bus.done_wmask[c*32 +: 32]; hit = 1;
          end
          if (!hit) m_eu = 1;
        end
      end
    end
    if (pop) begin
      m_cv = 1; m_cid = q[0].id; m_ccore = q[0].core; m_cwm = q[0].wm;
      void'(q.pop_front());
    end else if (m_cv && bus.commit_ready) m_cv = 0;
    if (aok) q.push_back('{bus.alloc_id, 1'b0, 2'd0, 32'd0});
  endfunction
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic idle();
    bus.alloc_valid = 0; bus.alloc_id = '0; bus.done_valid = '0; bus.done_id = '0; bus.done_wmask = '0; flush = 0;
  endtask
  task automatic col_tick();
    if (bus.commit_valid && bus.commit_ready) begin
      gid.push_back(bus.commit_id); gcore.push_back(bus.commit_core); gwm.push_back(bus.commit_wmask);
    end
    tick();
  endtask
  task automatic alloc(logic [7:0] id);
    bus.alloc_valid = 1; bus.alloc_id = id;
    col_tick();
    idle();
  endtask
  task automatic set_done(int c, logic [7:0] id);
    bus.done_valid[c] = 1; bus.done_id[c*IW +: IW] = id; bus.done_wmask[c*32 +: 32] = wmf(id, c);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0; idle(); model_reset();
    gid.delete(); gcore.delete(); gwm.delete();
    @(negedge clk);
    rst = 1;
  endtask
  task automatic test_reset();
    idle(); bus.commit_ready = 1; model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %b want 1", bus.alloc_ready); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got %b want 0", bus.commit_valid); end
    checks++; if ({bus.commit_id, bus.commit_core, bus.commit_wmask} !== '0) begin errors++; $display("FAIL reset_commit_fields got %h/%0d/%h want 0", bus.commit_id, bus.commit_core, bus.commit_wmask); end
    checks++; if ({eu, ed} !== 2'b00) begin errors++; $display("FAIL reset_err got %b%b want 00", eu, ed); end
  endtask
  task automatic test_out_of_order();
    do_reset(); bus.commit_ready = 1;
    alloc(8'h10); alloc(8'h11); alloc(8'h12);
    set_done(2, 8'h12); col_tick(); idle();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_early1 got commit_valid %b want 0", bus.commit_valid); end
    set_done(0, 8'h10); col_tick(); idle();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_early2 got commit_valid %b want 0", bus.commit_valid); end
    set_done(1, 8'h11); col_tick(); idle();
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_id !== 8'h10) begin errors++; $display("FAIL ooo_latency got %b/%h want 1/10", bus.commit_valid, bus.commit_id); end
    repeat (5) col_tick();
    checks++; if (gid.size() != 3) begin errors++; $display("FAIL ooo_count got %0d commits want 3", gid.size()); end
    for (int k = 0; k < 3 && k < gid.size(); k++) begin
      checks++;
      if (gid[k] !== 8'(8'h10 + k) || gcore[k] !== 2'(k) || gwm[k] !== wmf(8'(8'h10 + k), k)) begin
        errors++; $display("FAIL ooo_commit%0d got %h/%0d/%h want %h/%0d/%h", k, gid[k], gcore[k], gwm[k], 8'(8'h10 + k), k, wmf(8'(8'h10 + k), k));
      end
    end
  endtask
  task automatic test_full_wrap();
    logic [7:0] exp_id;
    do_reset(); bus.commit_ready = 1;
    for (int i = 0; i < D; i++) alloc(8'(8'h30 + i));
    checks++; if (bus.alloc_ready !== 1'b0 || count !== 4'd8) begin errors++; $display("FAIL full_state got ready %b count %0d want 0/8", bus.alloc_ready, count); end
    alloc(8'h38);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_ninth got count %0d want 8", count); end
    set_done(0, 8'h30); col_tick(); idle();
    col_tick();
    checks++; if (bus.alloc_ready !== 1'b1 || count !== 4'd7) begin errors++; $display("FAIL full_pop got ready %b count %0d want 1/7", bus.alloc_ready, count); end
    alloc(8'h20);
    set_done(1, 8'h20); col_tick(); idle();
    for (int i = 1; i < D; i++) begin set_done(i % NC, 8'(8'h30 + i)); col_tick(); idle(); end
    repeat (12) col_tick();
    checks++; if (gid.size() != 9) begin errors++; $display("FAIL wrap_count got %0d commits want 9", gid.size()); end
    for (int k = 0; k < 9 && k < gid.size(); k++) begin
      exp_id = (k == 8) ? 8'h20 : 8'(8'h30 + k);
      checks++; if (gid[k] !== exp_id) begin errors++; $display("FAIL wrap_order%0d got %h want %h", k, gid[k], exp_id); end
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_drain got count %0d want 0", count); end
  endtask
  task automatic test_backpressure();
    do_reset(); bus.commit_ready = 1;
    alloc(8'h40); alloc(8'h41); alloc(8'h42);
    bus.commit_ready = 0;
    set_done(0, 8'h40); set_done(1, 8'h41); set_done(2, 8'h42); tick(); idle();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.commit_valid !== 1'b1 || bus.commit_id !== 8'h40 || bus.commit_core !== 2'd0) begin errors++; $display("FAIL bp_hold%0d got %b/%h/%0d want 1/40/0", i, bus.commit_valid, bus.commit_id, bus.commit_core); end
      tick();
    end
    bus.commit_ready = 1;
    tick();
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_id !== 8'h41) begin errors++; $display("FAIL bp_next got %b/%h want 1/41", bus.commit_valid, bus.commit_id); end
    tick();
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_id !== 8'h42) begin errors++; $display("FAIL bp_next2 got %b/%h want 1/42", bus.commit_valid, bus.commit_id); end
    tick();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", bus.commit_valid); end
  endtask
  task automatic test_simultaneous();
    logic [7:0] eid[3] = '{8'h01, 8'h02, 8'h03};
    logic [1:0] ecore[3] = '{2'd1, 2'd2, 2'd0};
    do_reset(); bus.commit_ready = 1;
    alloc(8'h01); alloc(8'h02); alloc(8'h03);
    set_done(0, 8'h03); set_done(1, 8'h01); set_done(2, 8'h02); col_tick(); idle();
    repeat (5) col_tick();
    checks++; if (gid.size() != 3) begin errors++; $display("FAIL sim_count got %0d commits want 3", gid.size()); end
    for (int k = 0; k < 3 && k < gid.size(); k++) begin
      checks++; if (gid[k] !== eid[k] || gcore[k] !== ecore[k] || gwm[k] !== wmf(eid[k], int'(ecore[k]))) begin errors++; $display("FAIL sim_commit%0d got %h/%0d/%h want %h/%0d", k, gid[k], gcore[k], gwm[k], eid[k], ecore[k]); end
    end
    checks++; if ({eu, ed} !== 2'b00) begin errors++; $display("FAIL sim_noerr got %b%b want 00", eu, ed); end
    alloc(8'h05);
    set_done(0, 8'h05); set_done(1, 8'h05); col_tick(); idle();
    repeat (3) col_tick();
    checks++; if (gid.size() != 4 || gid[gid.size()-1] !== 8'h05 || gcore[gid.size()-1] !== 2'd0 || gwm[gid.size()-1] !== wmf(8'h05, 0)) begin errors++; $display("FAIL dup_winner got %0d commits, last core %0d want core 0", gid.size(), gcore[gid.size()-1]); end
    checks++; if (ed !== 1'b1 || eu !== 1'b0) begin errors++; $display("FAIL dup_flags got dup %b unk %b want 1/0", ed, eu); end
    set_done(2, 8'h7F); tick(); idle();
    checks++; if (eu !== 1'b1 || count !== 4'd0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL unknown got unk %b count %0d cv %b want 1/0/0", eu, count, bus.commit_valid); end
  endtask
  task automatic test_flush();
    do_reset(); bus.commit_ready = 0;
    alloc(8'h50); alloc(8'h51); alloc(8'h52); alloc(8'h53);
    set_done(0, 8'h50); tick(); idle();
    tick();
    checks++; if (bus.commit_valid !== 1'b1 || count !== 4'd3) begin errors++; $display("FAIL fl_pre got cv %b count %0d want 1/3", bus.commit_valid, count); end
    set_done(1, 8'h7E); tick(); idle();
    flush = 1; bus.alloc_valid = 1; bus.alloc_id = 8'h60; bus.commit_ready = 1;
    tick(); idle();
    checks++; if (count !== 4'd0 || bus.commit_valid !== 1'b0 || bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL fl_clear got count %0d cv %b ready %b want 0/0/1", count, bus.commit_valid, bus.alloc_ready); end
    checks++; if (eu !== 1'b1) begin errors++; $display("FAIL fl_err_kept got %b want 1", eu); end
    gid.delete();
    alloc(8'h61);
    set_done(2, 8'h61); col_tick(); idle();
    repeat (3) col_tick();
    checks++; if (gid.size() != 1 || gid[0] !== 8'h61 || gcore[0] !== 2'd2) begin errors++; $display("FAIL fl_after got %0d commits first %h want 1 of 61", gid.size(), gid[0]); end
  endtask
  task automatic test_midreset();
    do_reset(); bus.commit_ready = 0;
    alloc(8'h70); alloc(8'h71);
    set_done(0, 8'h70); tick(); idle();
    tick();
    #2;
    rst = 0; model_reset();
    #1;
    checks++; if (bus.commit_valid !== 1'b0 || count !== 4'd0 || bus.commit_id !== 8'h00 || bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL midreset got cv %b count %0d id %h ready %b want 0/0/00/1", bus.commit_valid, count, bus.commit_id, bus.alloc_ready); end
    @(negedge clk);
    rst = 1;
  endtask
  task automatic test_random();
    logic [7:0] nid = 8'h80;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      flush = ($urandom_range(0, 99) < 2);
      bus.commit_ready = ($urandom_range(0, 99) < 70);
      bus.alloc_valid = ($urandom_range(0, 99) < 60);
      bus.alloc_id = nid;
      if (bus.alloc_valid && !flush && q.size() < D) nid = nid + 8'd1;
      for (int c = 0; c < NC; c++) if ($urandom_range(0, 99) < 40) begin
        bus.done_valid[c] = 1;
        bus.done_id[c*IW +: IW] = (q.size() > 0 && $urandom_range(0, 99) < 90) ? q[$urandom_range(0, q.size() - 1)].id : 8'($urandom);
        bus.done_wmask[c*32 +: 32] = $urandom;
      end
      tick();
      checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", n, count, q.size()); end
      checks++; if (bus.alloc_ready !== (q.size() < D)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", n, bus.alloc_ready, q.size() < D); end
      checks++; if (bus.commit_valid !== m_cv) begin errors++; $display("FAIL rnd_cv cyc %0d got %b want %b", n, bus.commit_valid, m_cv); end
      if (m_cv) begin
        checks++; if (bus.commit_id !== m_cid || bus.commit_core !== m_ccore || bus.commit_wmask !== m_cwm) begin errors++; $display("FAIL rnd_commit cyc %0d got %h/%0d/%h want %h/%0d/%h", n, bus.commit_id, bus.commit_core, bus.commit_wmask, m_cid, m_ccore, m_cwm); end
      end
      checks++; if (eu !== m_eu || ed !== m_ed) begin errors++; $display("FAIL rnd_err cyc %0d got %b%b want %b%b", n, eu, ed, m_eu, m_ed); end
    end
  endtask
  initial begin
    test_reset();
    test_out_of_order();
    test_full_wrap();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
